// File: rtl/mem_bus_responder.sv
// Memory-side responder for the cpu_core memory bus. It holds a word-addressed RAM,
// accepts one CPU read or write at a time, and answers with a one-cycle bus_full
// strobe a fixed number of cycles after the request is sampled. It also provides a
// bench preload port that can write whole words while the responder is idle.
module mem_bus_responder #(
  parameter int unsigned WORDS   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_out,
  input  logic [31:0] data_out_BUS,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [3:0]  select,
  input  logic        pre_we,
  input  logic [31:0] pre_addr,
  input  logic [31:0] pre_data,
  output logic [31:0] data_in_BUS,
  output logic        bus_full,
  output logic        busy
);

  localparam int unsigned AW = $clog2(WORDS);
  // The first countdown cycle is spent in WAIT, so the strobe lands LATENCY edges
  // after the sampling edge. LATENCY=1 loads 0 and still passes through WAIT once.
  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ok_q, ok_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          full_q, full_d;

  logic [31:0]   mem [WORDS];

  logic [AW-1:0] cpu_idx, pre_idx;
  logic          cpu_ok, pre_ok;
  logic          pre_commit, cpu_commit;
  logic          unused_addr_lsbs;

  // Any address bit above the word index makes the access out of range.
  assign cpu_idx = address_out[AW+1:2];
  assign pre_idx = pre_addr[AW+1:2];
  assign cpu_ok  = (address_out >> (AW + 2)) == 32'd0;
  assign pre_ok  = (pre_addr >> (AW + 2)) == 32'd0;
  assign unused_addr_lsbs = ^{address_out[1:0], pre_addr[1:0]};

  assign pre_commit = pre_we && (state_q == StIdle) && pre_ok;
  assign cpu_commit = (state_q == StWait) && (cnt_q == 4'd0) && wr_q && ok_q;

  // Next-state, request latching and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    full_d  = 1'b0;
    unique case (state_q)
      // The response cycle doubles as an acceptance slot, so a held or fresh
      // request can start on the edge that leaves RESP (spacing LATENCY+1).
      StIdle, StResp: begin
        state_d = StIdle;
        if (read_en || write_en) begin
          state_d = StWait;
          cnt_d   = CntLoad;
          idx_d   = cpu_idx;
          ok_d    = cpu_ok;
          wdata_d = data_out_BUS;
          sel_d   = select;
          wr_d    = write_en;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          full_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = ok_q ? mem[idx_q] : 32'h0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      full_q  <= full_d;
    end
  end

  // RAM write port: preload only in IDLE, CPU byte writes on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (pre_commit) begin
      mem[pre_idx] <= pre_data;
    end else if (cpu_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign data_in_BUS = rdata_q;
  assign bus_full    = full_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a transaction-level model predicts bus_full,
// busy and data_in_BUS every cycle, and literal checks pin key scenarios.
module tb_mem_bus_responder;

  localparam int unsigned WORDS   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address_out = 32'h0;
  logic [31:0] data_out_BUS = 32'h0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [3:0]  select = 4'h0;
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_data = 32'h0;
  logic [31:0] data_in_BUS;
  logic        bus_full;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_bus_responder #(
    .WORDS   (WORDS),
    .LATENCY (LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address_out  (address_out),
    .data_out_BUS (data_out_BUS),
    .read_en      (read_en),
    .write_en     (write_en),
    .select       (select),
    .pre_we       (pre_we),
    .pre_addr     (pre_addr),
    .pre_data     (pre_data),
    .data_in_BUS  (data_in_BUS),
    .bus_full     (bus_full),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(WORDS * 4);
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, b};
  endfunction

  // Transaction-level model: edge numbers of acceptance and completion decide everything.
  int          e = 0;
  bit          t_valid = 1'b0;
  bit          t_wr, t_ok;
  int          t_acc, t_due, t_idx;
  logic [31:0] t_data;
  logic [3:0]  t_sel;
  logic [31:0] mmem [WORDS];
  logic [31:0] exp_data = 32'h0;
  logic        exp_full = 1'b0;
  logic        exp_busy = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      t_valid  = 1'b0;
      exp_full = 1'b0;
      exp_busy = 1'b0;
      exp_data = 32'h0;
    end else begin
      e++;
      exp_full = 1'b0;
      if (t_valid && e == t_due) begin
        exp_full = 1'b1;
        if (t_wr) begin
          if (t_ok) begin
            for (int b = 0; b < 4; b++) begin
              if (t_sel[b]) mmem[t_idx][8*b +: 8] = t_data[8*b +: 8];
            end
          end
        end else begin
          exp_data = t_ok ? mmem[t_idx] : 32'h0;
        end
      end
      if (pre_we && !(t_valid && t_acc < e && e <= t_due + 1) && in_rng(pre_addr)) begin
        mmem[int'(pre_addr / 4)] = pre_data;
      end
      if ((read_en || write_en) && !(t_valid && t_acc < e && e <= t_due)) begin
        t_valid = 1'b1;
        t_acc   = e;
        t_due   = e + int'(LATENCY);
        t_wr    = write_en;
        t_ok    = in_rng(address_out);
        t_idx   = t_ok ? int'(address_out / 4) : 0;
        t_data  = data_out_BUS;
        t_sel   = select;
      end
      exp_busy = t_valid && t_acc <= e && e <= t_due;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("model_bus_full", {31'b0, bus_full}, {31'b0, exp_full});
      chk("model_busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("model_data_in_BUS", data_in_BUS, exp_data);
    end
  end

  task automatic wait_full(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      pre_we = 1'b0;
      waited++;
    end while (!bus_full && waited < 20);
    read_en  = 1'b0;
    write_en = 1'b0;
    chk("bus_full_seen", {31'b0, bus_full}, 32'h1);
  endtask

  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, output int waited);
    @(negedge clk);
    read_en      = rd;
    write_en     = wr;
    address_out  = addr;
    data_out_BUS = data;
    select       = sel;
    wait_full(waited);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    int         w;
    logic [5:0] seen;

    // Reset state.
    #2 rst = 1'b1;
    #1;
    chk("rst_data", data_in_BUS, 32'h0);
    chk("rst_full", {31'b0, bus_full}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill every word so all later reads have a known value.
    for (int i = 0; i < int'(WORDS); i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 32'(i * 4);
      pre_data = pat(i);
    end
    @(negedge clk);
    pre_we = 1'b0;
    preload(32'h0, 32'h00302083);
    preload(32'h10, 32'h11223344);
    preload(32'h20, 32'h55667788);

    // Read with fixed latency; data held after the strobe.
    cpu_op(1, 0, 32'h0, 32'h0, 4'h0, w);
    chk("rd0_latency", 32'(w), 32'd3);
    chk("rd0_data", data_in_BUS, 32'h00302083);
    repeat (3) @(negedge clk);
    chk("rd0_held", data_in_BUS, 32'h00302083);

    // Byte-enable write; writes leave data_in_BUS alone.
    cpu_op(0, 1, 32'h10, 32'hDEADBEEF, 4'b0011, w);
    chk("wr10_latency", 32'(w), 32'd3);
    chk("wr10_keeps_data", data_in_BUS, 32'h00302083);
    cpu_op(0, 1, 32'h10, 32'h99999999, 4'b0000, w);
    cpu_op(1, 0, 32'h10, 32'h0, 4'h0, w);
    chk("rd10_merged", data_in_BUS, 32'h1122BEEF);

    // Held request: one response per acceptance, second accepted on the RESP exit edge.
    @(negedge clk);
    read_en     = 1'b1;
    address_out = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen[k] = bus_full;
    end
    read_en = 1'b0;
    chk("held_pattern", {26'b0, seen}, 32'b100100);
    repeat (4) @(negedge clk);

    // Preload while busy is ignored.
    @(negedge clk);
    read_en     = 1'b1;
    address_out = 32'h10;
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 32'h44;
    pre_data = 32'hFEEDFACE;
    wait_full(w);
    chk("rd10_again", data_in_BUS, 32'h1122BEEF);
    cpu_op(1, 0, 32'h44, 32'h0, 4'h0, w);
    chk("pre_busy_ignored", data_in_BUS, 32'hA511EE11);

    // Preload and request on the same idle edge.
    @(negedge clk);
    pre_we      = 1'b1;
    pre_addr    = 32'h40;
    pre_data    = 32'h12345678;
    read_en     = 1'b1;
    address_out = 32'h40;
    wait_full(w);
    chk("pre_req_latency", 32'(w), 32'd3);
    chk("pre_req_data", data_in_BUS, 32'h12345678);

    // Out-of-range accesses.
    cpu_op(1, 0, 32'h0000_0400, 32'h0, 4'h0, w);
    chk("oor_rd_latency", 32'(w), 32'd3);
    chk("oor_rd_data", data_in_BUS, 32'h0);
    cpu_op(0, 1, 32'h0000_0400, 32'hFFFFFFFF, 4'hF, w);
    cpu_op(1, 0, 32'h0000_0004, 32'h0, 4'h0, w);
    chk("rd4_data", data_in_BUS, 32'hA501FE01);
    cpu_op(1, 0, 32'h8000_0000, 32'h0, 4'h0, w);
    chk("oor_hi_data", data_in_BUS, 32'h0);
    preload(32'h0000_0400, 32'hFFFFFFFF);

    // Every word must still match the model.
    for (int i = 0; i < int'(WORDS); i++) begin
      cpu_op(1, 0, 32'(i * 4), 32'h0, 4'h0, w);
      chk("sweep", data_in_BUS, mmem[i]);
    end

    // Reset during WAIT aborts the write.
    @(negedge clk);
    write_en     = 1'b1;
    address_out  = 32'h20;
    data_out_BUS = 32'hCAFEF00D;
    select       = 4'hF;
    @(negedge clk);
    #2 rst = 1'b1;
    write_en = 1'b0;
    #1;
    chk("midrst_data", data_in_BUS, 32'h0);
    chk("midrst_full", {31'b0, bus_full}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cpu_op(1, 0, 32'h20, 32'h0, 4'h0, w);
    chk("rd20_after_abort", data_in_BUS, 32'h55667788);

    // read_en & write_en together is a write.
    cpu_op(1, 1, 32'h24, 32'h0BADF00D, 4'hF, w);
    chk("rw_keeps_data", data_in_BUS, 32'h55667788);
    cpu_op(1, 0, 32'h24, 32'h0, 4'h0, w);
    chk("rd24_written", data_in_BUS, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
